crypto_receipt_verifier: RTL and testbench
==========================================

// Module: crypto_receipt_verifier
// PURPOSE
//  Receiver/checker end of the receipt hash chain H_t = SHA256(H_{t-1} || dState || mu_op).
//  Accepts receipts (header + replayed serialized-state byte stream) and recomputes each hash
//  through an external sha256_interface. Checks chain linkage, hash equality and mu budget.
//  Sits beside the CPU/replay path; its verdicts gate receipt acceptance and audit logging.
// PARAMETERS
//  MU_HASH_COST   100   expected mu-cost (cycles) of one hash
//  MU_TOLERANCE   20    receipt mu_cost above MU_HASH_COST+MU_TOLERANCE is a budget error
//  TIMEOUT_CYCLES 4096  max cycles in STREAM+WAIT_HASH per receipt
// PORTS
//  clk            in   1    clock
//  rst            in   1    synchronous active-high reset
//  rcpt_valid     in   1    receipt header valid
//  rcpt_ready     out  1    header accepted when valid&&ready
//  rcpt_first     in   1    genesis receipt: skip link check, restart chain
//  rcpt_prev_hash in   256  H_{t-1} claimed by receipt
//  rcpt_hash      in   256  H_t claimed by receipt
//  rcpt_mu_cost   in   32   mu cost claimed by receipt
//  in_byte        in   8    serialized-state byte
//  in_byte_valid  in   1    byte valid
//  in_byte_last   in   1    final byte of this receipt's stream
//  in_byte_ready  out  1    byte consumed when valid&&ready
//  sha_start      out  1    1-cycle pulse: begin hash
//  sha_ready      in   1    engine idle
//  sha_byte       out  8    byte to engine
//  sha_byte_valid out  1    byte valid to engine
//  sha_byte_ready in   1    engine accepts byte
//  sha_byte_last  out  1    final byte to engine
//  sha_prev_hash  out  256  chain seed to engine (= rcpt_prev_hash latched)
//  sha_use_chain  out  1    = !rcpt_first latched
//  sha_valid      in   1    engine result valid (1 cycle)
//  sha_hash_in    in   256  engine result
//  verdict_valid  out  1    1-cycle pulse per receipt
//  verdict_ok     out  1    receipt passed all checks (valid with verdict_valid)
//  err_code       out  3    0 OK,1 LINK,2 TIMEOUT,3 HASH,4 MU (valid with verdict_valid)
//  chain_broken   out  1    sticky: any failure since last accepted genesis
//  chain_len      out  32   receipts accepted OK
//  mu_total       out  64   sum of mu_cost of OK receipts
//  last_hash      out  256  hash of last OK receipt
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, latched header 0.
//  FSM: IDLE -> CHECK -> (START -> STREAM -> WAIT_HASH | DRAIN) -> REPORT -> IDLE.
//  IDLE: rcpt_ready=1; on handshake latch header, rcpt_ready=0 next cycle.
//  CHECK (1 cycle): link_err = !first && prev_hash!=last_hash (chain_len==0 && !first -> link_err);
//   mu_err = mu_cost > MU_HASH_COST+MU_TOLERANCE (32-bit unsigned compare). link_err -> DRAIN,
//   else -> START.
//  START: wait sha_ready, pulse sha_start one cycle -> STREAM.
//  STREAM: combinational pass-through: sha_byte=in_byte, sha_byte_valid=in_byte_valid,
//   sha_byte_last=in_byte_last, in_byte_ready=sha_byte_ready. Accepted byte with last -> WAIT_HASH.
//  WAIT_HASH: on sha_valid compare sha_hash_in vs latched rcpt_hash -> REPORT.
//  DRAIN: in_byte_ready=1, bytes discarded, nothing sent to engine; last byte -> REPORT.
//  Timeout counter clears in CHECK, counts in STREAM/WAIT_HASH; reaching TIMEOUT_CYCLES -> REPORT
//   with TIMEOUT; remaining bytes of that receipt are not drained (upstream must reset).
//  REPORT: verdict_valid=1 one cycle. Error priority LINK > TIMEOUT > HASH > MU.
//   OK: last_hash<=rcpt_hash, chain_len+=1 (wraps), mu_total+=zero-extended mu_cost.
//   Error: last_hash/chain_len/mu_total unchanged, chain_broken<=1.
//   OK genesis: chain_len<=1, mu_total<=mu_cost, chain_broken<=0.
//  Every receipt carries >=1 byte; stray bytes in IDLE/CHECK/START are not accepted (ready=0).
//  sha_valid outside WAIT_HASH ignored. rst mid-receipt returns to IDLE, clears all counters.
//  Latency (no stalls): header-accept to verdict_valid = N_bytes + engine latency + 4 cycles.
// TESTING
//  Genesis rcpt (first=1, 4 bytes), engine returns matching hash -> ok=1,err=0,chain_len=1,
//   last_hash=rcpt_hash.
//  Second rcpt prev_hash=last_hash, match, mu_cost=90 -> ok, chain_len=2, mu_total=sum.
//  Second rcpt prev_hash!=last_hash -> err=1, 0 sha_start pulses, bytes drained, chain_broken=1.
//  Engine returns hash differing in bit 0 -> err=3, chain_len unchanged.
//  mu_cost=121 with matching hash -> err=4; mu_cost=120 -> ok.
//  Engine never asserts sha_valid -> err=2 after 4096 cycles; then rst -> all outputs 0.

Source files
------------

// File: rtl/crypto_receipt_verifier.sv
// crypto_receipt_verifier
//   Receiver/checker end of the receipt hash chain
//   H_t = SHA256(H_{t-1} || dState || mu_op).
//   A receipt is a header followed by its replayed serialized-state bytes.
//   Each receipt's hash is recomputed by an external SHA-256 engine. The block
//   then checks the chain linkage, hash equality and the mu budget, and reports
//   one verdict per receipt.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rcpt_*              receipt header handshake (valid/ready) and fields
//   in_byte*            serialized-state byte stream (valid/ready/last)
//   sha_*               SHA-256 engine control, byte stream, chain seed and result
//   verdict_valid       1-cycle pulse per receipt, qualifies verdict_ok/err_code
//   chain_broken        sticky failure flag since the last accepted genesis
//   chain_len/mu_total  count and mu sum of receipts accepted OK
//   last_hash           hash of the last receipt accepted OK
module crypto_receipt_verifier #(
  parameter int MU_HASH_COST   = 100,
  parameter int MU_TOLERANCE   = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rcpt_valid,
  output logic         rcpt_ready,
  input  logic         rcpt_first,
  input  logic [255:0] rcpt_prev_hash,
  input  logic [255:0] rcpt_hash,
  input  logic [31:0]  rcpt_mu_cost,
  input  logic [7:0]   in_byte,
  input  logic         in_byte_valid,
  input  logic         in_byte_last,
  output logic         in_byte_ready,
  output logic         sha_start,
  input  logic         sha_ready,
  output logic [7:0]   sha_byte,
  output logic         sha_byte_valid,
  input  logic         sha_byte_ready,
  output logic         sha_byte_last,
  output logic [255:0] sha_prev_hash,
  output logic         sha_use_chain,
  input  logic         sha_valid,
  input  logic [255:0] sha_hash_in,
  output logic         verdict_valid,
  output logic         verdict_ok,
  output logic [2:0]   err_code,
  output logic         chain_broken,
  output logic [31:0]  chain_len,
  output logic [63:0]  mu_total,
  output logic [255:0] last_hash
);

  localparam logic [31:0] MU_LIMIT = 32'(MU_HASH_COST + MU_TOLERANCE);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_LINK    = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_HASH    = 3'd3;
  localparam logic [2:0] ERR_MU      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_STREAM,
    S_WAIT_HASH,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t state, state_n;

  // Latched header
  logic         use_chain_q;
  logic [255:0] prev_hash_q;
  logic [255:0] hash_q;
  logic [31:0]  mu_q;

  // Per-receipt error flags
  logic         link_err_q;
  logic         mu_err_q;
  logic         hash_err_q;
  logic         tmo_err_q;
  logic [31:0]  tmo_cnt;

  logic         tmo_hit;
  logic         link_chk;
  logic         byte_acc;
  logic [2:0]   err_now;

  // Single error code from the flags, highest priority first.
  function automatic logic [2:0] encode_err(input logic link, input logic tmo,
                                            input logic hash, input logic mu);
    logic [2:0] code;
    code = ERR_OK;
    if (link)      code = ERR_LINK;
    else if (tmo)  code = ERR_TIMEOUT;
    else if (hash) code = ERR_HASH;
    else if (mu)   code = ERR_MU;
    return code;
  endfunction

  // A non-genesis receipt with no accepted predecessor can never link.
  assign link_chk = use_chain_q && ((chain_len == 32'd0) || (prev_hash_q != last_hash));
  assign tmo_hit  = ((state == S_STREAM) || (state == S_WAIT_HASH)) && (tmo_cnt == TMO_LAST);
  assign byte_acc = in_byte_valid && sha_byte_ready && in_byte_last;
  assign err_now  = encode_err(link_err_q, tmo_err_q, hash_err_q, mu_err_q);

  assign sha_prev_hash = prev_hash_q;
  assign sha_use_chain = use_chain_q;

  always_comb begin
    state_n        = state;
    rcpt_ready     = 1'b0;
    in_byte_ready  = 1'b0;
    sha_start      = 1'b0;
    sha_byte       = 8'd0;
    sha_byte_valid = 1'b0;
    sha_byte_last  = 1'b0;
    verdict_valid  = 1'b0;
    verdict_ok     = 1'b0;
    err_code       = ERR_OK;
    case (state)
      S_IDLE: begin
        rcpt_ready = !rst;
        if (rcpt_valid) state_n = S_CHECK;
      end
      S_CHECK: begin
        state_n = link_chk ? S_DRAIN : S_START;
      end
      S_START: begin
        if (sha_ready) begin
          sha_start = 1'b1;
          state_n   = S_STREAM;
        end
      end
      S_STREAM: begin
        sha_byte       = in_byte;
        sha_byte_valid = in_byte_valid;
        sha_byte_last  = in_byte_last;
        in_byte_ready  = sha_byte_ready;
        if (tmo_hit)       state_n = S_REPORT;
        else if (byte_acc) state_n = S_WAIT_HASH;
      end
      S_WAIT_HASH: begin
        if (tmo_hit || sha_valid) state_n = S_REPORT;
      end
      S_DRAIN: begin
        in_byte_ready = 1'b1;
        if (in_byte_valid && in_byte_last) state_n = S_REPORT;
      end
      S_REPORT: begin
        verdict_valid = 1'b1;
        verdict_ok    = (err_now == ERR_OK);
        err_code      = err_now;
        state_n       = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      use_chain_q  <= 1'b0;
      prev_hash_q  <= '0;
      hash_q       <= '0;
      mu_q         <= '0;
      link_err_q   <= 1'b0;
      mu_err_q     <= 1'b0;
      hash_err_q   <= 1'b0;
      tmo_err_q    <= 1'b0;
      tmo_cnt      <= '0;
      chain_broken <= 1'b0;
      chain_len    <= '0;
      mu_total     <= '0;
      last_hash    <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (rcpt_valid) begin
            use_chain_q <= !rcpt_first;
            prev_hash_q <= rcpt_prev_hash;
            hash_q      <= rcpt_hash;
            mu_q        <= rcpt_mu_cost;
          end
        end
        S_CHECK: begin
          link_err_q <= link_chk;
          mu_err_q   <= (mu_q > MU_LIMIT);
          hash_err_q <= 1'b0;
          tmo_err_q  <= 1'b0;
          tmo_cnt    <= '0;
        end
        S_STREAM: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (tmo_hit) tmo_err_q <= 1'b1;
        end
        S_WAIT_HASH: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (tmo_hit)        tmo_err_q  <= 1'b1;
          else if (sha_valid) hash_err_q <= (sha_hash_in != hash_q);
        end
        // ---- verdict commit: chain state only advances on an OK receipt
        S_REPORT: begin
          if (err_now == ERR_OK) begin
            last_hash <= hash_q;
            if (!use_chain_q) begin
              chain_len    <= 32'd1;
              mu_total     <= {32'd0, mu_q};
              chain_broken <= 1'b0;
            end else begin
              chain_len <= chain_len + 32'd1;
              mu_total  <= mu_total + {32'd0, mu_q};
            end
          end else begin
            chain_broken <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_receipt_verifier.sv
module tb_crypto_receipt_verifier;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rcpt_valid = 1'b0;
  logic         rcpt_ready;
  logic         rcpt_first = 1'b0;
  logic [255:0] rcpt_prev_hash = '0;
  logic [255:0] rcpt_hash = '0;
  logic [31:0]  rcpt_mu_cost = '0;
  logic [7:0]   in_byte = '0;
  logic         in_byte_valid = 1'b0;
  logic         in_byte_last = 1'b0;
  logic         in_byte_ready;
  logic         sha_start;
  logic         sha_ready = 1'b1;
  logic [7:0]   sha_byte;
  logic         sha_byte_valid;
  logic         sha_byte_ready = 1'b1;
  logic         sha_byte_last;
  logic [255:0] sha_prev_hash;
  logic         sha_use_chain;
  logic         sha_valid = 1'b0;
  logic [255:0] sha_hash_in = '0;
  logic         verdict_valid;
  logic         verdict_ok;
  logic [2:0]   err_code;
  logic         chain_broken;
  logic [31:0]  chain_len;
  logic [63:0]  mu_total;
  logic [255:0] last_hash;

  crypto_receipt_verifier dut (
    .clk(clk), .rst(rst),
    .rcpt_valid(rcpt_valid), .rcpt_ready(rcpt_ready), .rcpt_first(rcpt_first),
    .rcpt_prev_hash(rcpt_prev_hash), .rcpt_hash(rcpt_hash), .rcpt_mu_cost(rcpt_mu_cost),
    .in_byte(in_byte), .in_byte_valid(in_byte_valid), .in_byte_last(in_byte_last),
    .in_byte_ready(in_byte_ready),
    .sha_start(sha_start), .sha_ready(sha_ready), .sha_byte(sha_byte),
    .sha_byte_valid(sha_byte_valid), .sha_byte_ready(sha_byte_ready),
    .sha_byte_last(sha_byte_last), .sha_prev_hash(sha_prev_hash),
    .sha_use_chain(sha_use_chain), .sha_valid(sha_valid), .sha_hash_in(sha_hash_in),
    .verdict_valid(verdict_valid), .verdict_ok(verdict_ok), .err_code(err_code),
    .chain_broken(chain_broken), .chain_len(chain_len), .mu_total(mu_total),
    .last_hash(last_hash)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ok;
    logic [2:0]   err;
    logic [31:0]  len;
    logic [63:0]  mu;
    logic [255:0] last;
    logic         broken;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  localparam logic [255:0] HA = 256'hA5A5_0001_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
  localparam logic [255:0] HB = 256'hB0B0_0002_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F0F_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [255:0] HC = 256'hC0C0_0003_DEAD_BEEF_CAFE_BABE_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999;
  localparam logic [255:0] HD = 256'hD0D0_0004_1357_9BDF_2468_ACE0_1111_1111_2222_2222_3333_3333_4444_4444_5555_5555;
  localparam logic [255:0] HE = 256'hE0E0_0005_AAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA_5554;
  localparam logic [255:0] HF = 256'hF0F0_0006_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [255:0] HG = 256'h1234_0007_9999_8888_7777_6666_5555_4444_3333_2222_1111_0000_FFFF_EEEE_DDDD_CCCC;

  // Engine model state
  logic [255:0] eng_hash    = '0;
  logic         eng_respond = 1'b1;
  int           eng_lat     = 3;
  int           eng_cd      = 0;
  int           start_cnt   = 0;
  int           byte_cnt    = 0;
  logic [255:0] seen_prev   = '0;
  logic         seen_chain  = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // SHA engine stand-in: counts starts/bytes, answers after eng_lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      sha_valid = 1'b0;
      if (sha_start) begin
        start_cnt++;
        seen_prev  = sha_prev_hash;
        seen_chain = sha_use_chain;
      end
      if (sha_byte_valid && sha_byte_ready) begin
        byte_cnt++;
        if (sha_byte_last && eng_respond) eng_cd = eng_lat;
      end else if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0) begin
          sha_valid   = 1'b1;
          sha_hash_in = eng_hash;
        end
      end
    end
  end

  // Verdict monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (verdict_valid) begin
        if (sb.size() == 0) begin
          bound_fail("unexpected_verdict");
        end else begin
          e = sb.pop_front();
          chk("verdict_ok", 256'(verdict_ok), 256'(e.ok));
          chk("err_code", 256'(err_code), 256'(e.err));
          @(negedge clk);
          chk("verdict_pulse", 256'(verdict_valid), 256'(0));
          chk("chain_len", 256'(chain_len), 256'(e.len));
          chk("mu_total", 256'(mu_total), 256'(e.mu));
          chk("last_hash", last_hash, e.last);
          chk("chain_broken", 256'(chain_broken), 256'(e.broken));
        end
      end
    end
  end

  task automatic send_rcpt(input logic first, input logic [255:0] prev, input logic [255:0] hsh,
                           input logic [31:0] mu, input int nb, input logic [255:0] eh,
                           input logic resp, input exp_t e);
    int n;
    sb.push_back(e);
    eng_hash       = eh;
    eng_respond    = resp;
    rcpt_first     = first;
    rcpt_prev_hash = prev;
    rcpt_hash      = hsh;
    rcpt_mu_cost   = mu;
    rcpt_valid     = 1'b1;
    n = 0;
    while (!rcpt_ready && n < 100) begin @(negedge clk); n++; end
    if (!rcpt_ready) begin
      bound_fail("rcpt_ready");
      rcpt_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rcpt_valid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      in_byte       = 8'(i * 17 + 3);
      in_byte_valid = 1'b1;
      in_byte_last  = (i == nb - 1);
      n = 0;
      while (!in_byte_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_byte_ready) begin
        bound_fail("in_byte_ready");
        in_byte_valid = 1'b0;
        in_byte_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_byte_valid = 1'b0;
    in_byte_last  = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      bound_fail("verdict_wait");
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rcpt_ready"}, 256'(rcpt_ready), 256'(0));
    chk({tag, "_in_byte_ready"}, 256'(in_byte_ready), 256'(0));
    chk({tag, "_sha_start"}, 256'(sha_start), 256'(0));
    chk({tag, "_sha_use_chain"}, 256'(sha_use_chain), 256'(0));
    chk({tag, "_sha_prev_hash"}, sha_prev_hash, 256'(0));
    chk({tag, "_verdict_valid"}, 256'(verdict_valid), 256'(0));
    chk({tag, "_err_code"}, 256'(err_code), 256'(0));
    chk({tag, "_chain_len"}, 256'(chain_len), 256'(0));
    chk({tag, "_mu_total"}, 256'(mu_total), 256'(0));
    chk({tag, "_last_hash"}, last_hash, 256'(0));
    chk({tag, "_chain_broken"}, 256'(chain_broken), 256'(0));
  endtask

  initial begin
    int s0, b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rcpt_ready", 256'(rcpt_ready), 256'(1));

    // Genesis, 4 bytes, matching hash
    s0 = start_cnt; b0 = byte_cnt;
    send_rcpt(1'b1, '0, HA, 32'd100, 4, HA, 1'b1, '{1'b1, 3'd0, 32'd1, 64'd100, HA, 1'b0});
    wait_done(200);
    chk("gen_starts", 256'(start_cnt - s0), 256'(1));
    chk("gen_bytes", 256'(byte_cnt - b0), 256'(4));
    chk("gen_use_chain", 256'(seen_chain), 256'(0));

    // Linked receipt, mu 90
    s0 = start_cnt; b0 = byte_cnt;
    send_rcpt(1'b0, HA, HB, 32'd90, 3, HB, 1'b1, '{1'b1, 3'd0, 32'd2, 64'd190, HB, 1'b0});
    wait_done(200);
    chk("link_starts", 256'(start_cnt - s0), 256'(1));
    chk("link_bytes", 256'(byte_cnt - b0), 256'(3));
    chk("link_use_chain", 256'(seen_chain), 256'(1));
    chk("link_seed", seen_prev, HA);

    // Broken link: drained, engine untouched
    s0 = start_cnt; b0 = byte_cnt;
    send_rcpt(1'b0, HC, HD, 32'd10, 5, HD, 1'b1, '{1'b0, 3'd1, 32'd2, 64'd190, HB, 1'b1});
    wait_done(200);
    chk("linkerr_starts", 256'(start_cnt - s0), 256'(0));
    chk("linkerr_bytes", 256'(byte_cnt - b0), 256'(0));

    // New genesis clears chain_broken
    send_rcpt(1'b1, HG, HD, 32'd50, 2, HD, 1'b1, '{1'b1, 3'd0, 32'd1, 64'd50, HD, 1'b0});
    wait_done(200);

    // Engine hash differs in bit 0
    send_rcpt(1'b0, HD, HE, 32'd10, 4, HE ^ 256'd1, 1'b1, '{1'b0, 3'd3, 32'd1, 64'd50, HD, 1'b1});
    wait_done(200);

    // mu budget boundary: 121 fails, 120 passes
    send_rcpt(1'b0, HD, HF, 32'd121, 1, HF, 1'b1, '{1'b0, 3'd4, 32'd1, 64'd50, HD, 1'b1});
    wait_done(200);
    send_rcpt(1'b0, HD, HF, 32'd120, 1, HF, 1'b1, '{1'b1, 3'd0, 32'd2, 64'd170, HF, 1'b1});
    wait_done(200);

    // Link error outranks mu error
    send_rcpt(1'b0, HA, HG, 32'd500, 2, HG, 1'b1, '{1'b0, 3'd1, 32'd2, 64'd170, HF, 1'b1});
    wait_done(200);

    // Hash error outranks mu error
    send_rcpt(1'b0, HF, HG, 32'd121, 2, HA, 1'b1, '{1'b0, 3'd3, 32'd2, 64'd170, HF, 1'b1});
    wait_done(200);

    // Engine never answers: timeout
    send_rcpt(1'b0, HF, HG, 32'd1, 3, HG, 1'b0, '{1'b0, 3'd2, 32'd2, 64'd170, HF, 1'b1});
    wait_done(5000);

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("rst2");
    rst = 1'b0;
    @(negedge clk);

    // Non-genesis with empty chain cannot link even though prev equals last_hash (0)
    send_rcpt(1'b0, '0, HA, 32'd5, 2, HA, 1'b1, '{1'b0, 3'd1, 32'd0, 64'd0, 256'd0, 1'b1});
    wait_done(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
